// File: rtl/memory_bank_if.sv
// rtl/memory_bank_if.sv - write/read/clear bus between a client and the memory bank.
interface memory_bank_if #(
    parameter int WIDTH  = 24,
    parameter int ADDR_W = 4
);
    logic              ce;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  d;
    logic              re;
    logic [ADDR_W-1:0] raddr;
    logic [WIDTH-1:0]  q;
    logic              q_valid;
    logic              clear;
    logic              busy;

    modport master (
        output ce, we, waddr, d, re, raddr, clear,
        input  q, q_valid, busy
    );

    modport slave (
        input  ce, we, waddr, d, re, raddr, clear,
        output q, q_valid, busy
    );
endinterface

// File: rtl/memory_bank.sv
// rtl/memory_bank.sv - DEPTH x WIDTH storage with registered read port and sequential clear sweep.
module memory_bank #(
    parameter int WIDTH  = 24,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic          clk,
    input  logic          reset,
    memory_bank_if.slave  bus
);
    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              q_valid_q, q_valid_d;

    logic [WIDTH-1:0]  mem [DEPTH];

    logic busy;
    logic waddr_ok;
    logic raddr_ok;
    logic wr_acc;
    logic rd_acc;

    assign busy     = (state_q == S_CLEAR);
    assign waddr_ok = ({1'b0, bus.waddr} < DEPTH_C);
    assign raddr_ok = ({1'b0, bus.raddr} < DEPTH_C);
    assign wr_acc   = bus.ce & bus.we & ~busy & waddr_ok;
    assign rd_acc   = bus.ce & bus.re & ~busy;

    // A clear request in IDLE still lets that cycle's read/write through; CLEAR ignores it.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST_PTR) begin
                    state_d = S_IDLE;
                    ptr_d   = '0;
                end
            end
            S_IDLE: begin
                if (bus.clear) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = S_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_comb begin
        q_d       = q_q;
        q_valid_d = 1'b0;
        if (rd_acc) begin
            q_valid_d = 1'b1;
            if (!raddr_ok) begin
                q_d = '0;
            end else if (wr_acc && (bus.waddr == bus.raddr)) begin
                q_d = bus.d;
            end else begin
                q_d = mem[bus.raddr];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_CLEAR;
            ptr_q     <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
        end
    end

    // The array has no reset; the sweep is the only way it is zeroed.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem[ptr_q] <= '0;
        end else if (wr_acc) begin
            mem[bus.waddr] <= bus.d;
        end
    end

    assign bus.q       = q_q;
    assign bus.q_valid = q_valid_q;
    assign bus.busy    = busy;
endmodule

// File: tb/tb_memory_bank.sv
// tb/tb_memory_bank.sv - scoreboard bench for memory_bank at DEPTH=16 and DEPTH=10.
module tb_memory_bank;
    typedef struct packed {
        logic        v;
        logic [23:0] d;
    } exp_t;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    exp_t exp_q[$];
    exp_t e;

    memory_bank_if #(.WIDTH(24), .ADDR_W(4)) bus ();
    memory_bank_if #(.WIDTH(24), .ADDR_W(4)) bus_s ();

    memory_bank #(.WIDTH(24), .DEPTH(16), .ADDR_W(4)) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    memory_bank #(.WIDTH(24), .DEPTH(10), .ADDR_W(4)) u_small (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_s.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.ce = 0; bus.we = 0; bus.re = 0; bus.clear = 0;
        bus.waddr = '0; bus.raddr = '0; bus.d = '0;
        bus_s.ce = 0; bus_s.we = 0; bus_s.re = 0; bus_s.clear = 0;
        bus_s.waddr = '0; bus_s.raddr = '0; bus_s.d = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int cnt;
        reset = 0;
        idle_inputs();
        repeat (3) tick();
        checks++;
        if (bus.busy !== 1'b1 || bus.q !== 24'h0 || bus.q_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state busy=%b q=%h q_valid=%b required busy=1 q=0 q_valid=0",
                     bus.busy, bus.q, bus.q_valid);
        end
        reset = 1;
        cnt = 0;
        while (bus.busy && cnt < 100) begin
            tick();
            cnt++;
        end
        checks++;
        if (cnt !== 16) begin
            errors++;
            $display("FAIL reset_sweep_len got=%0d required=16", cnt);
        end
        for (int i = 0; i < 16; i++) begin
            bus.ce = 1; bus.re = 1; bus.raddr = 4'(i);
            exp_q.push_back('{v: 1'b1, d: 24'h0});
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({bus.q_valid, bus.q} !== e) begin
                errors++;
                $display("FAIL reset_readback[%0d] got=%b/%h required=%b/%h",
                         i, bus.q_valid, bus.q, e.v, e.d);
            end
        end
        idle_inputs();
    endtask

    task automatic test_write_read();
        bus.ce = 1; bus.we = 1; bus.waddr = 3; bus.d = 24'hABCDEF;
        tick();
        bus.we = 0; bus.re = 1; bus.raddr = 3;
        exp_q.push_back('{v: 1'b1, d: 24'hABCDEF});
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({bus.q_valid, bus.q} !== e) begin
            errors++;
            $display("FAIL read_addr3 got=%b/%h required=%b/%h", bus.q_valid, bus.q, e.v, e.d);
        end
        bus.re = 0;
        tick();
        checks++;
        if (bus.q_valid !== 1'b0 || bus.q !== 24'hABCDEF) begin
            errors++;
            $display("FAIL q_hold got=%b/%h required=0/abcdef", bus.q_valid, bus.q);
        end
        bus.re = 1; bus.raddr = 4;
        exp_q.push_back('{v: 1'b1, d: 24'h0});
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({bus.q_valid, bus.q} !== e) begin
            errors++;
            $display("FAIL read_addr4 got=%b/%h required=%b/%h", bus.q_valid, bus.q, e.v, e.d);
        end
        idle_inputs();
    endtask

    task automatic test_write_first();
        bus.ce = 1; bus.we = 1; bus.waddr = 5; bus.d = 24'h000123;
        bus.re = 1; bus.raddr = 5;
        exp_q.push_back('{v: 1'b1, d: 24'h000123});
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({bus.q_valid, bus.q} !== e) begin
            errors++;
            $display("FAIL write_first got=%b/%h required=%b/%h", bus.q_valid, bus.q, e.v, e.d);
        end
        bus.waddr = 6; bus.d = 24'h000456; bus.raddr = 3;
        exp_q.push_back('{v: 1'b1, d: 24'hABCDEF});
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({bus.q_valid, bus.q} !== e) begin
            errors++;
            $display("FAIL independent_rw got=%b/%h required=%b/%h", bus.q_valid, bus.q, e.v, e.d);
        end
        bus.we = 0; bus.raddr = 6;
        exp_q.push_back('{v: 1'b1, d: 24'h000456});
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({bus.q_valid, bus.q} !== e) begin
            errors++;
            $display("FAIL read_addr6 got=%b/%h required=%b/%h", bus.q_valid, bus.q, e.v, e.d);
        end
        idle_inputs();
    endtask

    task automatic test_clear();
        int cnt;
        bus.ce = 1; bus.we = 1; bus.d = 24'h111111;
        for (int i = 0; i < 16; i++) begin
            bus.waddr = 4'(i);
            tick();
        end
        bus.we = 0; bus.clear = 1; bus.re = 1; bus.raddr = 0;
        exp_q.push_back('{v: 1'b1, d: 24'h111111});
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({bus.q_valid, bus.q} !== e || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_accept got=%b/%h busy=%b required=%b/%h busy=1",
                     bus.q_valid, bus.q, bus.busy, e.v, e.d);
        end
        bus.clear = 0; bus.we = 1; bus.waddr = 0; bus.d = 24'h222222; bus.raddr = 1;
        exp_q.push_back('{v: 1'b0, d: 24'h111111});
        cnt = 0;
        while (bus.busy && cnt < 100) begin
            bus.clear = (cnt == 7);
            tick();
            cnt++;
            if (cnt == 1) begin
                e = exp_q.pop_front();
                checks++;
                if ({bus.q_valid, bus.q} !== e) begin
                    errors++;
                    $display("FAIL busy_read_refused got=%b/%h required=%b/%h",
                             bus.q_valid, bus.q, e.v, e.d);
                end
                bus.we = 0; bus.re = 0;
            end
        end
        bus.clear = 0;
        checks++;
        if (cnt !== 16) begin
            errors++;
            $display("FAIL clear_sweep_len got=%0d required=16", cnt);
        end
        bus.re = 1;
        for (int i = 0; i < 16; i++) begin
            bus.raddr = 4'(i);
            exp_q.push_back('{v: 1'b1, d: 24'h0});
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({bus.q_valid, bus.q} !== e) begin
                errors++;
                $display("FAIL cleared_word[%0d] got=%b/%h required=%b/%h",
                         i, bus.q_valid, bus.q, e.v, e.d);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_sweep();
        int cnt;
        bus.ce = 1; bus.we = 1; bus.waddr = 2; bus.d = 24'h333333;
        tick();
        bus.we = 0; bus.re = 1; bus.raddr = 2; bus.clear = 1;
        tick();
        idle_inputs();
        repeat (10) tick();
        checks++;
        if (bus.q !== 24'h333333 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_q got=%h busy=%b required=333333 busy=1", bus.q, bus.busy);
        end
        reset = 0;
        #1;
        checks++;
        if (bus.q !== 24'h0 || bus.q_valid !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got q=%h q_valid=%b busy=%b required q=0 q_valid=0 busy=1",
                     bus.q, bus.q_valid, bus.busy);
        end
        repeat (2) tick();
        reset = 1;
        cnt = 0;
        while (bus.busy && cnt < 100) begin
            tick();
            cnt++;
        end
        checks++;
        if (cnt !== 16) begin
            errors++;
            $display("FAIL restart_sweep_len got=%0d required=16", cnt);
        end
    endtask

    task automatic test_small_depth();
        int cnt;
        idle_inputs();
        bus_s.clear = 1;
        tick();
        bus_s.clear = 0;
        cnt = 0;
        while (bus_s.busy && cnt < 100) begin
            tick();
            cnt++;
        end
        checks++;
        if (cnt !== 10) begin
            errors++;
            $display("FAIL small_sweep_len got=%0d required=10", cnt);
        end
        bus_s.ce = 1; bus_s.we = 1;
        for (int i = 0; i < 10; i++) begin
            bus_s.waddr = 4'(i); bus_s.d = 24'h000100 + 24'(i);
            tick();
        end
        bus_s.waddr = 12; bus_s.d = 24'hFFFFFF;
        tick();
        bus_s.we = 0; bus_s.re = 1; bus_s.raddr = 12;
        exp_q.push_back('{v: 1'b1, d: 24'h0});
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({bus_s.q_valid, bus_s.q} !== e) begin
            errors++;
            $display("FAIL small_oob_read got=%b/%h required=%b/%h", bus_s.q_valid, bus_s.q, e.v, e.d);
        end
        for (int i = 0; i < 10; i++) begin
            bus_s.raddr = 4'(i);
            exp_q.push_back('{v: 1'b1, d: 24'h000100 + 24'(i)});
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({bus_s.q_valid, bus_s.q} !== e) begin
                errors++;
                $display("FAIL small_word[%0d] got=%b/%h required=%b/%h",
                         i, bus_s.q_valid, bus_s.q, e.v, e.d);
            end
        end
        idle_inputs();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_write_read();
        test_write_first();
        test_clear();
        test_reset_mid_sweep();
        test_small_depth();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
